// File: rtl/conv_3x3_core_pkg.sv
// Shared constants, FSM states and default kernel for the 3x3 conv core.
// Imported by the interface, the pixel RAM and the top.
package conv_3x3_core_pkg;

  localparam int IMG_W = 8;
  localparam int OUT_W = 6;
  localparam int N_OUT = 36;
  localparam int PIX_W = 8;
  localparam int ACC_W = 16;
  localparam int AW    = 6;
  localparam int KW    = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_LAST,
    S_EMIT
  } state_e;

  localparam logic [KW-1:0] K00_DEF = 4'd1;
  localparam logic [KW-1:0] K01_DEF = 4'd2;
  localparam logic [KW-1:0] K02_DEF = 4'd1;
  localparam logic [KW-1:0] K10_DEF = 4'd2;
  localparam logic [KW-1:0] K11_DEF = 4'd4;
  localparam logic [KW-1:0] K12_DEF = 4'd2;
  localparam logic [KW-1:0] K20_DEF = 4'd1;
  localparam logic [KW-1:0] K21_DEF = 4'd2;
  localparam logic [KW-1:0] K22_DEF = 4'd1;

endpackage

// File: rtl/conv_3x3_core_if.sv
// Host-side bus of the conv core: pixel load/readback, start, results.
// master = host/collector side, slave = conv_3x3_core.
interface conv_3x3_core_if;
  import conv_3x3_core_pkg::*;

  logic             wr;
  logic [AW-1:0]    address;
  logic [PIX_W-1:0] din;
  logic [PIX_W-1:0] rd_data;
  logic             in_st;
  logic [ACC_W-1:0] dout;
  logic             out_st;
  logic             busy;

  modport master (
    output wr, address, din, in_st,
    input  rd_data, dout, out_st, busy
  );

  modport slave (
    input  wr, address, din, in_st,
    output rd_data, dout, out_st, busy
  );

endinterface

// File: rtl/conv_pixel_ram.sv
// 64x8 pixel store: one sync write port, one sync read port, no reset.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (1 cycle).
module conv_pixel_ram
  import conv_3x3_core_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/conv_3x3_core.sv
// 8x8 image RAM plus 3x3 valid-convolution engine, 11 cycles per result.
// Ports: clk, rst (async high), bus (slave): wr/address/din/rd_data, in_st, dout/out_st/busy.
module conv_3x3_core
  import conv_3x3_core_pkg::*;
#(
  parameter logic [KW-1:0] K00 = K00_DEF,
  parameter logic [KW-1:0] K01 = K01_DEF,
  parameter logic [KW-1:0] K02 = K02_DEF,
  parameter logic [KW-1:0] K10 = K10_DEF,
  parameter logic [KW-1:0] K11 = K11_DEF,
  parameter logic [KW-1:0] K12 = K12_DEF,
  parameter logic [KW-1:0] K20 = K20_DEF,
  parameter logic [KW-1:0] K21 = K21_DEF,
  parameter logic [KW-1:0] K22 = K22_DEF
) (
  input logic              clk,
  input logic              rst,
  conv_3x3_core_if.slave   bus
);

  localparam logic [2:0] LAST_RC = 3'(OUT_W - 1);

  state_e           state_q;
  logic [2:0]       r_q, c_q;
  logic [1:0]       tr_q, tc_q;
  logic [3:0]       ki_q;
  logic             vld_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] dout_q;
  logic             out_st_q;
  logic             busy_q;
  logic             rdv_q;

  logic             idle;
  logic             we;
  logic [2:0]       prow, pcol;
  logic [AW-1:0]    raddr;
  logic [PIX_W-1:0] ram_q;
  logic [KW-1:0]    kcur;
  logic [ACC_W-1:0] prod;

  assign idle  = (state_q == S_IDLE);
  assign we    = bus.wr && idle;
  assign prow  = r_q + {1'b0, tr_q};
  assign pcol  = c_q + {1'b0, tc_q};
  assign raddr = idle ? bus.address : {prow, pcol};

  conv_pixel_ram u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (bus.address),
    .wdata_i (bus.din),
    .raddr_i (raddr),
    .rdata_o (ram_q)
  );

  // ki_q names the tap whose pixel is on ram_q this cycle
  always_comb begin
    kcur = '0;
    unique case (ki_q)
      4'd0:    kcur = K00;
      4'd1:    kcur = K01;
      4'd2:    kcur = K02;
      4'd3:    kcur = K10;
      4'd4:    kcur = K11;
      4'd5:    kcur = K12;
      4'd6:    kcur = K20;
      4'd7:    kcur = K21;
      4'd8:    kcur = K22;
      default: kcur = '0;
    endcase
  end

  assign prod  = ACC_W'(kcur) * ACC_W'(ram_q);
  assign acc_d = acc_q + (vld_q ? prod : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      c_q      <= '0;
      tr_q     <= '0;
      tc_q     <= '0;
      ki_q     <= '0;
      vld_q    <= 1'b0;
      acc_q    <= '0;
      dout_q   <= '0;
      out_st_q <= 1'b0;
      busy_q   <= 1'b0;
      rdv_q    <= 1'b0;
    end else begin
      // readback is only meaningful once the RAM port ran an idle cycle
      rdv_q <= idle;
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_st) begin
            state_q <= S_READ;
            busy_q  <= 1'b1;
            r_q     <= '0;
            c_q     <= '0;
            tr_q    <= '0;
            tc_q    <= '0;
            acc_q   <= '0;
            vld_q   <= 1'b0;
          end
        end
        S_READ: begin
          vld_q <= 1'b1;
          ki_q  <= 4'(tr_q) * 4'd3 + 4'(tc_q);
          acc_q <= acc_d;
          if (tc_q == 2'd2) begin
            tc_q <= '0;
            if (tr_q == 2'd2)
              state_q <= S_LAST;
            else
              tr_q <= tr_q + 2'd1;
          end else begin
            tc_q <= tc_q + 2'd1;
          end
        end
        S_LAST: begin
          acc_q    <= acc_d;
          dout_q   <= acc_d;
          out_st_q <= 1'b1;
          vld_q    <= 1'b0;
          state_q  <= S_EMIT;
        end
        S_EMIT: begin
          out_st_q <= 1'b0;
          acc_q    <= '0;
          tr_q     <= '0;
          tc_q     <= '0;
          if (r_q == LAST_RC && c_q == LAST_RC) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_READ;
            if (c_q == LAST_RC) begin
              c_q <= '0;
              r_q <= r_q + 3'd1;
            end else begin
              c_q <= c_q + 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dout    = dout_q;
  assign bus.out_st  = out_st_q;
  assign bus.busy    = busy_q;
  assign bus.rd_data = rdv_q ? ram_q : '0;

endmodule

// File: tb/tb_conv_3x3_core.sv
// Scoreboard bench for conv_3x3_core: model pushes 36 sums per run,
// monitor pops on each out_st and checks value and 11-cycle spacing.
module tb_conv_3x3_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_3x3_core_if bus ();

  conv_3x3_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int unsigned last_t = 0;
  int          strobes = 0;
  int unsigned exp_q[$];
  int          img[64];
  int          kern[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int unsigned got,
                     int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  function automatic int unsigned conv_at(int r, int c);
    int unsigned s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += kern[i*3+j] * img[(r+i)*8 + c + j];
    return s;
  endfunction

  always @(negedge clk) begin
    if (bus.out_st === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0)
        chk("extra_strobe", 1, 0);
      else
        chk($sformatf("dout[%0d]", strobes - 1),
            bus.dout, exp_q.pop_front());
      chk("spacing", cyc - last_t, 11);
      last_t = cyc;
    end
  end

  task automatic wr_pix(int a, int d);
    @(negedge clk);
    bus.wr      = 1'b1;
    bus.address = 6'(a);
    bus.din     = 8'(d);
    img[a]      = d;
  endtask

  // mode 0: constant v, mode 1: ramp r*8+c
  task automatic load(int mode, int v);
    for (int a = 0; a < 64; a++)
      wr_pix(a, (mode == 1) ? a : v);
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  // optional host write in the same cycle as the start pulse
  task automatic start_run(bit with_wr, int a, int d);
    if (with_wr) img[a] = d;
    for (int k = 0; k < 36; k++)
      exp_q.push_back(conv_at(k / 6, k % 6));
    @(negedge clk);
    bus.in_st = 1'b1;
    if (with_wr) begin
      bus.wr      = 1'b1;
      bus.address = 6'(a);
      bus.din     = 8'(d);
    end
    strobes = 0;
    @(posedge clk);
    #1;
    last_t    = cyc - 1;
    bus.in_st = 1'b0;
    bus.wr    = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("busy_drop", bus.busy, 0);
    chk("strobe_count", strobes, 36);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic readback(int a, int exp);
    @(negedge clk);
    bus.address = 6'(a);
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", a), bus.rd_data, exp);
  endtask

  initial begin
    int cnt;
    bus.wr      = 1'b0;
    bus.address = '0;
    bus.din     = '0;
    bus.in_st   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_st", bus.out_st, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    rst = 1'b0;

    // all 10s: every result 160
    load(0, 10);
    start_run(0, 0, 0);
    wait_done();

    // ramp
    load(1, 0);
    start_run(0, 0, 0);
    wait_done();

    // all 255, readback, then write + start together
    load(0, 255);
    readback(63, 255);
    start_run(0, 0, 0);
    wait_done();
    start_run(1, 0, 0);
    wait_done();
    readback(0, 0);

    // ramp with dropped write and start re-pulses mid-run
    load(1, 0);
    start_run(0, 0, 0);
    repeat (50) @(negedge clk);
    bus.wr      = 1'b1;
    bus.address = 6'd0;
    bus.din     = 8'd99;
    bus.in_st   = 1'b1;
    repeat (20) @(negedge clk);
    chk("busy_mid", bus.busy, 1);
    bus.wr    = 1'b0;
    bus.in_st = 1'b0;
    wait_done();
    readback(0, 0);

    // async reset right after the 10th strobe
    start_run(0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_st === 1'b1) cnt++;
      if (cnt == 10) break;
    end
    chk("tenth_strobe", cnt, 10);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_st", bus.out_st, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_dout", bus.dout, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    readback(9, 9);
    readback(42, 42);
    start_run(0, 0, 0);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
